// File: rtl/led_timer_multi_if.sv
// Register access bus for the multi-channel LED timer: one-cycle write strobe
// and a read strobe whose data returns registered on the following cycle.
interface led_timer_multi_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              wr_en_i;
    logic [ADDR_W-1:0] addr_i;
    logic [CNT_W-1:0]  wr_data_i;
    logic              rd_en_i;
    logic [CNT_W-1:0]  rd_data_o;

    modport master (
        output wr_en_i, addr_i, wr_data_i, rd_en_i,
        input  rd_data_o
    );

    modport slave (
        input  wr_en_i, addr_i, wr_data_i, rd_en_i,
        output rd_data_o
    );
endinterface

// File: rtl/led_timer_multi.sv
// Multi-channel LED timer: per-channel OFF/ON/BLINK/PWM driven by a shared tick prescaler.
// Latency: led_o one clk after counter/phase state; rd_data_o one clk after rd_en_i.
// Backpressure: none; writes and reads always accepted, ena_i low freezes all timing.
module led_timer_multi #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 16,
    parameter int PRESC  = 50000,
    parameter int ADDR_W = $clog2(CH_NUM) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena_i,
    led_timer_multi_if.slave  bus,
    output logic              tick_o,
    output logic [CH_NUM-1:0] led_o
);
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    localparam int PCNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESC - 1);

    logic [PCNT_W-1:0] pcnt;
    logic [ADDR_W-1:0] ch_sel;
    logic [1:0]        reg_sel;
    logic [CH_NUM-1:0] wr_hit;
    logic [CNT_W-1:0]  rd_val;

    mode_t             mode_q   [CH_NUM];
    logic [CNT_W-1:0]  period_q [CH_NUM];
    logic [CNT_W-1:0]  duty_q   [CH_NUM];
    logic [CNT_W-1:0]  cnt_q    [CH_NUM];
    logic [CH_NUM-1:0] phase_q;

    assign ch_sel  = bus.addr_i >> 2;
    assign reg_sel = bus.addr_i[1:0];
    assign tick_o  = ena_i && (pcnt == PCNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (ena_i) begin
            pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + PCNT_W'(1);
        end
    end

    // Out-of-range channel indices match no wr_hit bit, so those writes vanish.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            wr_hit[i] = bus.wr_en_i && (ch_sel == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CH_NUM; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= '0;
                duty_q[i]   <= '0;
                cnt_q[i]    <= '0;
            end
            phase_q <= '0;
            led_o   <= '0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (wr_hit[i]) begin
                    case (reg_sel)
                        2'd0:    mode_q[i]   <= mode_t'(bus.wr_data_i[1:0]);
                        2'd1:    period_q[i] <= bus.wr_data_i;
                        2'd2:    duty_q[i]   <= bus.wr_data_i;
                        default: ;
                    endcase
                end
                // A MODE/PERIOD write restarts the channel and overrides a coincident tick.
                if (wr_hit[i] && (reg_sel == 2'd0 || reg_sel == 2'd1)) begin
                    cnt_q[i]   <= '0;
                    phase_q[i] <= 1'b0;
                end else if (tick_o) begin
                    if (cnt_q[i] == period_q[i]) begin
                        cnt_q[i]   <= '0;
                        phase_q[i] <= ~phase_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
                case (mode_q[i])
                    MODE_OFF:   led_o[i] <= 1'b0;
                    MODE_ON:    led_o[i] <= 1'b1;
                    MODE_BLINK: led_o[i] <= phase_q[i];
                    MODE_PWM:   led_o[i] <= (cnt_q[i] < duty_q[i]);
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                case (reg_sel)
                    2'd0:    rd_val = CNT_W'(mode_q[i]);
                    2'd1:    rd_val = period_q[i];
                    2'd2:    rd_val = duty_q[i];
                    default: rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rd_data_o <= '0;
        end else if (bus.rd_en_i) begin
            bus.rd_data_o <= rd_val;
        end
    end
endmodule
